// File: rtl/cpu_mem_responder.sv
// Word-addressed backing store answering CPU data-memory requests after a fixed
// number of wait states, with a one-cycle ack carrying read data or an error flag.
module cpu_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clk,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_be,
    output logic        o_ready,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    // state  | meaning
    // S_IDLE | no transaction in flight, ready for a request
    // S_WAIT | request latched, counting down wait states
    // S_RESP | ack cycle; a new request may be accepted here
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] LIMIT    = 30'(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic          r_we;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_enter_resp;
    logic [31:0]   w_t_addr;
    logic          w_t_we;
    logic [31:0]   w_t_wdata;
    logic [3:0]    w_t_be;
    logic          w_t_err;
    logic [AW-1:0] w_idx;

    assign w_accept     = (r_state != S_WAIT) && i_req && i_enable;
    assign w_enter_resp = ((r_state == S_WAIT) && (r_cnt == 4'd0)) ||
                          (w_accept && (WAIT_STATES == 0));

    // With no wait states the transaction completes on the accept edge itself,
    // so it must be served from the live inputs rather than the latches.
    generate
        if (WAIT_STATES == 0) begin : g_direct
            assign w_t_addr  = i_addr;
            assign w_t_we    = i_we;
            assign w_t_wdata = i_wdata;
            assign w_t_be    = i_be;
        end else begin : g_latched
            assign w_t_addr  = r_addr;
            assign w_t_we    = r_we;
            assign w_t_wdata = r_wdata;
            assign w_t_be    = r_be;
        end
    endgenerate

    assign w_t_err = (w_t_addr[1:0] != 2'b00) || (w_t_addr[31:2] >= LIMIT);
    assign w_idx   = w_t_addr[2 +: AW];

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (r_state != S_WAIT);
        o_ack   = (r_state == S_RESP);
        o_err   = (r_state == S_RESP) && r_err;
        o_rdata = r_rdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr;
                r_we    <= i_we;
                r_wdata <= i_wdata;
                r_be    <= i_be;
                r_cnt   <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_err <= w_t_err;
                if (!w_t_we) begin
                    r_rdata <= w_t_err ? 32'd0 : r_mem[w_idx];
                end
            end
        end
    end

    // Store is deliberately not cleared; clear only blocks a pending write.
    always_ff @(posedge i_clk) begin
        if (!i_clear && w_enter_resp && w_t_we && !w_t_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_t_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_t_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: one instance with two wait states and
// one with none, expected responses queued at accept and compared at ack.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        clear, enable, req, we, sel;
    logic [31:0] addr, wdata;
    logic [3:0]  be;

    logic        ready2, ack2, err2, ready0, ack0, err0;
    logic [31:0] rdata2, rdata0;
    logic        req2, req0;

    assign req2 = req & ~sel;
    assign req0 = req & sel;

    cpu_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut (
        .i_clk(clk), .i_clear(clear), .i_enable(enable), .i_req(req2), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .i_be(be),
        .o_ready(ready2), .o_ack(ack2), .o_rdata(rdata2), .o_err(err2)
    );

    cpu_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_clear(clear), .i_enable(enable), .i_req(req0), .i_we(we),
        .i_addr(addr), .i_wdata(wdata), .i_be(be),
        .o_ready(ready0), .o_ack(ack0), .o_rdata(rdata0), .o_err(err0)
    );

    logic        ready, ack, err;
    logic [31:0] rdata;
    assign ready = sel ? ready0 : ready2;
    assign ack   = sel ? ack0   : ack2;
    assign err   = sel ? err0   : err2;
    assign rdata = sel ? rdata0 : rdata2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          ack_cnt = 0;
    int          last_ack = -1;
    logic        b2b = 1'b0;
    logic [31:0] mmem [256];
    logic [31:0] m_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack) begin
            ack_cnt++;
            if (sb.size() == 0) begin
                check("spurious_ack", 32'(ack), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("rdata", rdata, e_mon.rdata);
                check("err", 32'(err), 32'(e_mon.err));
                check("latency", 32'(cyc - e_mon.acc), sel ? 32'd1 : 32'd3);
                if (b2b && last_ack >= 0)
                    check("ack_gap", 32'(cyc - last_ack), sel ? 32'd1 : 32'd3);
            end
            last_ack = cyc;
        end else if (err) begin
            check("err_without_ack", 32'(err), 32'd0);
        end
    end

    // Reference model: applied in accept order, so queued expectations see prior writes.
    task automatic expect_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b);
        exp_t       e;
        logic       er;
        logic [7:0] idx;
        er    = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
        idx   = a[9:2];
        e.acc = cyc;
        e.err = er;
        if (er) begin
            if (!w) m_rdata = 32'd0;
        end else if (w) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) mmem[idx][8*i +: 8] = d[8*i +: 8];
        end else begin
            m_rdata = mmem[idx];
        end
        e.rdata = m_rdata;
        sb.push_back(e);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input bit keep, output int waited);
        bit got;
        we = w; addr = a; wdata = d; be = b; req = 1'b1;
        waited = 0;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (ready && enable) begin
                expect_txn(w, a, d, b);
                got = 1;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            check("accept_timeout", 32'd0, 32'd1);
            req = 1'b0;
        end else begin
            @(posedge clk); #1;
            if (!keep) req = 1'b0;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 60 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int w;
        xfer(1'b1, a, d, b, 1'b0, w);
        wait_idle();
    endtask

    task automatic rd(input logic [31:0] a);
        int w;
        xfer(1'b0, a, 32'd0, 4'd0, 1'b0, w);
        wait_idle();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        m_rdata = 32'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, ac;
        logic [31:0] data [4];
        data[0] = 32'hA5A5_0001; data[1] = 32'h0BAD_F00D;
        data[2] = 32'h1357_9BDF; data[3] = 32'hFFFF_0000;

        sel = 1'b0; clear = 1'b1; enable = 1'b1; req = 1'b0;
        we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;

        // T1 reset values and quiet idle
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        ac = ack_cnt;
        repeat (10) @(posedge clk);
        #1 check("idle_no_ack", 32'(ack_cnt), 32'(ac));

        // T2 full write then read
        wr(32'h10, 32'hDEAD_BEEF, 4'hF);
        rd(32'h10);

        // T3 byte enables
        wr(32'h10, 32'h0000_AA00, 4'b0010);
        rd(32'h10);
        check("be_merge_model", m_rdata, 32'hDEAD_AAEF);
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h10);

        // T4 errors leave the store untouched
        wr(32'h0, 32'hCAFE_F00D, 4'hF);
        rd(32'h12);
        wr(32'h400, 32'h1111_1111, 4'hF);
        rd(32'h10);
        rd(32'h0);

        // T5 back-to-back writes with two wait states
        b2b = 1'b1; last_ack = -1;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 32'h20 + 32'(4*i), data[i], 4'hF, i < 3, w);
        wait_idle();
        b2b = 1'b0;
        for (int i = 0; i < 4; i++) rd(32'h20 + 32'(4*i));

        // T6 abort by clear one cycle after accept
        we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; be = 4'hF; req = 1'b1;
        @(negedge clk);
        check("abort_pre_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        req = 1'b0; clear = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0; m_rdata = 32'd0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_rdata", rdata, 32'd0);
        ac = ack_cnt;
        repeat (6) @(posedge clk);
        #1 check("abort_no_ack", 32'(ack_cnt), 32'(ac));
        rd(32'h20);

        // T6 enable gating
        enable = 1'b0; we = 1'b0; addr = 32'h24; req = 1'b1;
        ac = ack_cnt;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        check("dis_ready", 32'(ready), 32'd1);
        check("dis_no_ack", 32'(ack_cnt), 32'(ac));
        @(posedge clk); #1;
        enable = 1'b1;
        xfer(1'b0, 32'h24, 32'd0, 4'd0, 1'b0, w);
        check("en_accept_wait", 32'(w), 32'd0);
        wait_idle();

        // T5 repeated with zero wait states: ack every cycle
        sel = 1'b1;
        pulse_clear();
        b2b = 1'b1; last_ack = -1;
        for (int i = 0; i < 4; i++)
            xfer(1'b1, 32'h40 + 32'(4*i), data[i] ^ 32'h5A5A_5A5A, 4'hF, 1'b1, w);
        for (int i = 0; i < 4; i++)
            xfer(1'b0, 32'h40 + 32'(4*i), 32'd0, 4'd0, i < 3, w);
        wait_idle();
        b2b = 1'b0;
        rd(32'h43);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
